// File: rtl/sc_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers, status flags,
// synchronous flush and optional same-cycle pass-through when empty.
module sc_fifo #(
  parameter bit PASS_THRU  = 1'b0,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  srst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  output logic                  full,
  output logic                  afull,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  pull,
  output logic                  empty,
  output logic                  aempty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE     = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] AFULL_COUNT = (ADDR_WIDTH+1)'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  reg_empty;
  logic                  reg_full;
  logic                  bypass;
  logic                  push_ok;
  logic                  pull_ok;

  assign reg_empty = (wptr == rptr);
  assign reg_full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                     (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
  assign count     = wptr - rptr;

  // A push+pull into an empty pass-through FIFO is consumed on the wire and never stored.
  assign bypass  = PASS_THRU && reg_empty && push && pull;
  assign push_ok = push && !reg_full && !bypass;
  assign pull_ok = pull && !reg_empty;

  assign full   = reg_full;
  assign afull  = (count == AFULL_COUNT);
  assign aempty = (count == PTR_ONE);
  assign empty  = (PASS_THRU && reg_empty) ? !push : reg_empty;

  always_comb begin
    data_out = mem[rptr[ADDR_WIDTH-1:0]];
    if (PASS_THRU && reg_empty) data_out = data_in;
  end

  always_ff @(posedge aclk) begin
    if (srst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pull_ok) rptr <= rptr + PTR_ONE;
    end
  end

  // Storage is never cleared; reset and flush only block the write.
  always_ff @(posedge aclk) begin
    if (!srst && !flush && push_ok) mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
  end

endmodule

// File: tb/tb_sc_fifo.sv
// Directed bench for sc_fifo: a 4-deep 16-bit FIFO without pass-through and a
// second instance with pass-through enabled.
module tb_sc_fifo;

  localparam int AW = 2;
  localparam int DW = 16;

  logic          aclk;
  logic          srst;
  logic          flush;
  logic [DW-1:0] data_in;
  logic          push;
  logic          pull;
  logic          full, afull, empty, aempty;
  logic [DW-1:0] data_out;

  logic [DW-1:0] pt_data_in;
  logic          pt_push, pt_pull;
  logic          pt_full, pt_afull, pt_empty, pt_aempty;
  logic [DW-1:0] pt_data_out;

  int vectors;
  int miscompares;

  sc_fifo #(.PASS_THRU(1'b0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .aclk(aclk), .srst(srst), .flush(flush), .data_in(data_in), .push(push),
    .full(full), .afull(afull), .data_out(data_out), .pull(pull),
    .empty(empty), .aempty(aempty)
  );

  sc_fifo #(.PASS_THRU(1'b1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut_pt (
    .aclk(aclk), .srst(srst), .flush(1'b0), .data_in(pt_data_in), .push(pt_push),
    .full(pt_full), .afull(pt_afull), .data_out(pt_data_out), .pull(pt_pull),
    .empty(pt_empty), .aempty(pt_aempty)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic e, input logic ae,
                             input logic af, input logic f);
    check({tag, ".empty"},  {15'd0, empty},  {15'd0, e});
    check({tag, ".aempty"}, {15'd0, aempty}, {15'd0, ae});
    check({tag, ".afull"},  {15'd0, afull},  {15'd0, af});
    check({tag, ".full"},   {15'd0, full},   {15'd0, f});
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    data_in = d;
    push    = 1'b1;
    tick();
    push    = 1'b0;
  endtask

  task automatic pull_word(input string tag, input logic [DW-1:0] exp);
    check(tag, data_out, exp);
    pull = 1'b1;
    tick();
    pull = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] next_d;
    vectors     = 0;
    miscompares = 0;
    srst = 1'b1; flush = 1'b0; data_in = '0; push = 1'b0; pull = 1'b0;
    pt_data_in = '0; pt_push = 1'b0; pt_pull = 1'b0;
    tick();
    tick();
    srst = 1'b0;
    check_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0);

    // first word: one-cycle latency without pass-through
    data_in = 16'h1111;
    push    = 1'b1;
    #1;
    check("nopt_same_cycle.empty", {15'd0, empty}, 16'd1);
    tick();
    push = 1'b0;
    check_flags("first", 1'b0, 1'b1, 1'b0, 1'b0);
    pull_word("first.data", 16'h1111);
    check_flags("first_pulled", 1'b1, 1'b0, 1'b0, 1'b0);

    // fill to full, overflow dropped, push+pull while full
    push_word(16'hA000);
    push_word(16'hA001);
    push_word(16'hA002);
    check_flags("fill3", 1'b0, 1'b0, 1'b1, 1'b0);
    push_word(16'hA003);
    check_flags("fill4", 1'b0, 1'b0, 1'b0, 1'b1);
    push_word(16'hBEEF);
    check_flags("overflow", 1'b0, 1'b0, 1'b0, 1'b1);
    check("overflow.head", data_out, 16'hA000);
    data_in = 16'hCAFE; push = 1'b1; pull = 1'b1;
    tick();
    push = 1'b0; pull = 1'b0;
    check_flags("full_pushpull", 1'b0, 1'b0, 1'b1, 1'b0);
    pull_word("drain.a001", 16'hA001);
    pull_word("drain.a002", 16'hA002);
    pull_word("drain.a003", 16'hA003);
    check_flags("drained", 1'b1, 1'b0, 1'b0, 1'b0);

    // steady-state stream across pointer wrap at count 2
    push_word(16'h0000);
    push_word(16'h0001);
    next_d = 16'h0002;
    for (int k = 0; k < 10; k++) begin
      check("stream.head", data_out, 16'(k));
      data_in = next_d; push = 1'b1; pull = 1'b1;
      tick();
      next_d = next_d + 16'd1;
    end
    push = 1'b0; pull = 1'b0;
    check_flags("stream_count2", 1'b0, 1'b0, 1'b0, 1'b0);
    pull_word("stream.tail0", 16'h000A);
    check_flags("stream_count1", 1'b0, 1'b1, 1'b0, 1'b0);
    pull_word("stream.tail1", 16'h000B);
    check_flags("stream_empty", 1'b1, 1'b0, 1'b0, 1'b0);

    // flush with a concurrent push
    push_word(16'hC000);
    push_word(16'hC001);
    push_word(16'hC002);
    check_flags("preflush", 1'b0, 1'b0, 1'b1, 1'b0);
    data_in = 16'hDEAD; push = 1'b1; flush = 1'b1;
    tick();
    push = 1'b0; flush = 1'b0;
    check_flags("flushed", 1'b1, 1'b0, 1'b0, 1'b0);
    push_word(16'hD00D);
    check("postflush.head", data_out, 16'hD00D);
    check_flags("postflush", 1'b0, 1'b1, 1'b0, 1'b0);
    pull_word("postflush.pull", 16'hD00D);

    // underflow ignored
    pull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_flags("underflow", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    pull = 1'b0;
    push_word(16'h7777);
    check("after_underflow.head", data_out, 16'h7777);
    check_flags("after_underflow", 1'b0, 1'b1, 1'b0, 1'b0);
    push_word(16'h8888);
    check_flags("prereset", 1'b0, 1'b0, 1'b0, 1'b0);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check_flags("midfill_reset", 1'b1, 1'b0, 1'b0, 1'b0);

    // pass-through instance
    pt_data_in = 16'h5A5A; pt_push = 1'b1; pt_pull = 1'b1;
    #1;
    check("pt_bypass.data", pt_data_out, 16'h5A5A);
    check("pt_bypass.empty", {15'd0, pt_empty}, 16'd0);
    tick();
    pt_push = 1'b0; pt_pull = 1'b0;
    #1;
    check("pt_after_bypass.empty", {15'd0, pt_empty}, 16'd1);
    check("pt_after_bypass.aempty", {15'd0, pt_aempty}, 16'd0);
    pt_data_in = 16'h1234; pt_push = 1'b1;
    #1;
    check("pt_push.data", pt_data_out, 16'h1234);
    check("pt_push.empty", {15'd0, pt_empty}, 16'd0);
    tick();
    pt_push = 1'b0; pt_data_in = 16'h0000;
    #1;
    check("pt_stored.data", pt_data_out, 16'h1234);
    check("pt_stored.empty", {15'd0, pt_empty}, 16'd0);
    check("pt_stored.aempty", {15'd0, pt_aempty}, 16'd1);
    check("pt_stored.full", {15'd0, pt_full}, 16'd0);
    check("pt_stored.afull", {15'd0, pt_afull}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
